countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Loadable mm:ss down-counter for the clock's timer function. It is the counting-down counterpart of the up-counting seconds/minutes chain: it consumes a one-cycle 1 Hz enable and decrements seconds, borrowing from minutes when seconds wrap. It emits a borrow pulse per minute and a done pulse when the count reaches 00:00. It sits beside the seconds/minutes counters and drives the display mux and alarm logic.

Parameters:
SEC_MAX, 59, highest seconds value; the value seconds reload to on a borrow.
MIN_MAX, 59, highest minutes value accepted on load.

Ports:
clk  input  1  system clock.
reset  input  1  reset, asynchronous, active-low.
tick  input  1  one-cycle enable, one pulse per second; meaningful only in RUN.
load  input  1  one-cycle strobe that captures min_in/sec_in.
min_in  input  6  minutes preset, binary.
sec_in  input  6  seconds preset, binary.
start  input  1  one-cycle strobe that starts or resumes counting.
pause  input  1  one-cycle strobe that freezes counting.
min_out  output  6  current minutes, binary.
sec_out  output  6  current seconds, binary.
running  output  1  high while in RUN.
borrow  output  1  one-cycle pulse when seconds wrap 0 -> SEC_MAX.
done  output  1  one-cycle pulse on reaching 00:00.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async):
  - min_out=0, sec_out=0, running=0, borrow=0, done=0.
  - State=IDLE.
  - Reset mid-run aborts immediately and nothing resumes after release.
- States: IDLE, RUN, PAUSED, DONE. State encoding is internal.
- Load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUN.
  - Inputs above the limit saturate: sec_in>SEC_MAX -> SEC_MAX; min_in>MIN_MAX -> MIN_MAX.
  - Loaded values appear on the outputs the cycle after the load strobe.
  - Load in PAUSED or DONE -> IDLE.
- IDLE:
  - start with a nonzero count -> RUN.
  - start with count 00:00 is ignored; stay in IDLE with no done pulse.
  - load and start in the same cycle: the loaded value is used for the zero check, and the state goes to RUN if that value is nonzero.
- RUN, on tick:
  - sec>0: sec-1.
  - sec=0 and min>0: sec=SEC_MAX, min-1, borrow=1 for one cycle.
  - If the new value is 00:00: go to DONE, done=1 for one cycle, running=0.
  - Outputs change the cycle after the sampled tick (latency 1).
  - With no tick, the value holds.
- RUN, other inputs:
  - pause -> PAUSED; the value holds and running=0 from the next cycle.
  - tick and pause in the same cycle: the tick decrement is applied, then the state goes to PAUSED. If that decrement reaches 00:00, DONE wins and pause is ignored.
  - start in RUN is ignored.
- PAUSED:
  - start -> RUN.
  - tick is ignored.
  - start and pause in the same cycle: pause wins, stay PAUSED.
- DONE:
  - Outputs hold at 00:00.
  - start and tick are ignored.
  - Only load (-> IDLE) or reset leaves DONE.
- running equals (state==RUN) and is registered together with the state.
- borrow and done are never high for more than one cycle.
- borrow is not asserted on the 01:00 -> 00:59 step when that step also reaches zero. That case cannot occur: 00:59 is nonzero. On 01:00 -> 00:59, borrow=1 and done=0.
- Arithmetic:
  - 6-bit unsigned.
  - The counters never underflow: decrement only occurs from a nonzero value.
  - min never exceeds MIN_MAX; sec never exceeds SEC_MAX.

Test Plan:
- Reset, then load min_in=0, sec_in=3, start, then 3 ticks spaced 5 cycles apart -> sec_out 3,2,1,0, each changing one cycle after its tick. On the cycle sec_out becomes 0: done=1 for exactly one cycle, running=0, state DONE. Further ticks change nothing.
- Load 01:00, start, 1 tick -> min_out=0, sec_out=59, borrow=1 for one cycle, done=0, running stays 1.
- Load 02:10, start, 4 ticks, pause on the same cycle as the 4th tick -> outputs 02:06, running=0. 10 further ticks: value unchanged. start, 1 tick -> 02:05.
- Load min_in=63, sec_in=60 -> outputs 59:59. start with count 00:00 (after reset, no load) -> no transition, running=0, done=0.
- In RUN at 00:45: assert load with 10:10 -> ignored, count continues. Assert reset low mid-run for 1 cycle -> outputs 0 immediately, state IDLE; release, then tick -> no change.
- From DONE: start is ignored. load 00:02 and start in the same cycle as a later load -> IDLE then RUN with 00:02; 2 ticks -> done pulse again.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and count bus of the mm:ss countdown timer.
// master drives strobes and presets; slave is the timer itself.
interface countdown_timer_if;
    logic       tick;
    logic       load;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       start;
    logic       pause;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       borrow;
    logic       done;

    modport master (
        output tick, load, min_in, sec_in, start, pause,
        input  min_out, sec_out, running, borrow, done
    );

    modport slave (
        input  tick, load, min_in, sec_in, start, pause,
        output min_out, sec_out, running, borrow, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable mm:ss down-counter advanced by a 1 Hz tick.
// Emits a borrow pulse per minute wrap and a done pulse on reaching 00:00.
module countdown_timer #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 59
) (
    input logic             clk,
    input logic             reset,
    countdown_timer_if.slave bus
);
    localparam logic [5:0] SecMax = 6'(SEC_MAX);
    localparam logic [5:0] MinMax = 6'(MIN_MAX);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    state_e     state;
    logic [5:0] min_q, sec_q;
    logic       running_q, borrow_q, done_q;
    logic [5:0] min_ld, sec_ld;
    logic       ld_nonzero, cur_nonzero, last_tick;

    always_comb begin
        min_ld      = (bus.min_in > MinMax) ? MinMax : bus.min_in;
        sec_ld      = (bus.sec_in > SecMax) ? SecMax : bus.sec_in;
        ld_nonzero  = (min_ld != 6'd0) || (sec_ld != 6'd0);
        cur_nonzero = (min_q != 6'd0) || (sec_q != 6'd0);
        last_tick   = bus.tick && (min_q == 6'd0) && (sec_q == 6'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            running_q <= 1'b0;
            borrow_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.load) begin
                        min_q <= min_ld;
                        sec_q <= sec_ld;
                    end
                    // A simultaneous load decides the zero check.
                    if (bus.start && (bus.load ? ld_nonzero : cur_nonzero)) begin
                        state     <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (bus.tick) begin
                        if (sec_q != 6'd0) begin
                            sec_q <= sec_q - 6'd1;
                        end else if (min_q != 6'd0) begin
                            sec_q    <= SecMax;
                            min_q    <= min_q - 6'd1;
                            borrow_q <= 1'b1;
                        end
                    end
                    if (last_tick) begin
                        state     <= StDone;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (bus.pause) begin
                        state     <= StPaused;
                        running_q <= 1'b0;
                    end
                end
                StPaused: begin
                    if (bus.load) begin
                        min_q <= min_ld;
                        sec_q <= sec_ld;
                        state <= StIdle;
                    end else if (bus.start && !bus.pause) begin
                        state     <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.load) begin
                        min_q <= min_ld;
                        sec_q <= sec_ld;
                        state <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_out = min_q;
    assign bus.sec_out = sec_q;
    assign bus.running = running_q;
    assign bus.borrow  = borrow_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: directed scenarios then random strobes,
// checked against a total-seconds reference model.
module tb_countdown_timer;
    localparam int SecMax = 59;
    localparam int MinMax = 59;
    localparam int MIdle = 0, MRun = 1, MPaused = 2, MDone = 3;

    typedef struct {
        int mn;
        int sc;
        bit run;
        bit brw;
        bit dn;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    countdown_timer_if bus ();

    countdown_timer #(
        .SEC_MAX(SecMax),
        .MIN_MAX(MinMax)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // Reference model: the count as a single number of seconds.
    int total = 0;
    int mode = MIdle;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push(input bit brw, input bit dn);
        exp_t e;
        e.mn  = total / (SecMax + 1);
        e.sc  = total % (SecMax + 1);
        e.run = (mode == MRun);
        e.brw = brw;
        e.dn  = dn;
        sb_q.push_back(e);
    endtask

    task automatic model_step(input bit ld, input bit st, input bit ps, input bit tk,
                              input int mi, input int si);
        bit brw = 1'b0;
        bit dn  = 1'b0;
        int ld_total = sat(mi, MinMax) * (SecMax + 1) + sat(si, SecMax);
        case (mode)
            MIdle: begin
                if (ld) total = ld_total;
                if (st && total != 0) mode = MRun;
            end
            MRun: begin
                if (tk) begin
                    if (total % (SecMax + 1) == 0) brw = 1'b1;
                    total = total - 1;
                end
                if (tk && total == 0) begin
                    mode = MDone;
                    dn   = 1'b1;
                end else if (ps) begin
                    mode = MPaused;
                end
            end
            MPaused: begin
                if (ld) begin
                    total = ld_total;
                    mode  = MIdle;
                end else if (st && !ps) begin
                    mode = MRun;
                end
            end
            default: begin
                if (ld) begin
                    total = ld_total;
                    mode  = MIdle;
                end
            end
        endcase
        push(brw, dn);
    endtask

    task automatic drive(input bit ld, input bit st, input bit ps, input bit tk,
                         input int mi, input int si);
        bus.load   = ld;
        bus.start  = st;
        bus.pause  = ps;
        bus.tick   = tk;
        bus.min_in = 6'(mi);
        bus.sec_in = 6'(si);
    endtask

    task automatic step(input bit ld, input bit st, input bit ps, input bit tk,
                        input int mi, input int si);
        @(negedge clk);
        reset = 1'b1;
        drive(ld, st, ps, tk, mi, si);
        model_step(ld, st, ps, tk, mi, si);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 0, 0);
            idle(gap);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("async_min", int'(bus.min_out), 0);
        chk("async_sec", int'(bus.sec_out), 0);
        chk("async_running", int'(bus.running), 0);
        total = 0;
        mode  = MIdle;
        push(1'b0, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("min_out", int'(bus.min_out), e.mn);
                chk("sec_out", int'(bus.sec_out), e.sc);
                chk("running", int'(bus.running), int'(e.run));
                chk("borrow", int'(bus.borrow), int'(e.brw));
                chk("done", int'(bus.done), int'(e.dn));
            end
        end
    end

    initial begin : stimulus
        int guard;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total = 0;
            mode  = MIdle;
            push(1'b0, 1'b0);
        end

        // start at 00:00 is ignored
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        // 00:03 down to done; further ticks do nothing
        step(1, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0, 0);
        tick_n(3, 4);
        tick_n(3, 1);

        // 01:00 -> 00:59 with borrow
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        tick_n(1, 2);
        step(0, 0, 1, 0, 0, 0);

        // 02:10, pause with 4th tick, ticks ignored, resume
        step(1, 0, 0, 0, 2, 10);
        step(0, 1, 0, 0, 0, 0);
        tick_n(3, 1);
        step(0, 0, 1, 1, 0, 0);
        tick_n(10, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        tick_n(1, 2);

        // saturating load from PAUSED
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 63, 60);
        idle(2);

        // load ignored while running, then async reset mid-run
        step(1, 0, 0, 0, 0, 46);
        step(0, 1, 0, 0, 0, 0);
        tick_n(1, 1);
        step(1, 0, 0, 0, 10, 10);
        tick_n(1, 1);
        async_reset();
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // DONE ignores start; load -> IDLE, load+start -> RUN
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        tick_n(1, 1);
        step(0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2);
        step(1, 1, 0, 0, 0, 2);
        tick_n(2, 1);

        // random strobes
        for (int i = 0; i < 3000; i++) begin
            bit ld = ($urandom_range(0, 24) == 0);
            bit st = ($urandom_range(0, 7) == 0);
            bit ps = ($urandom_range(0, 19) == 0);
            bit tk = ($urandom_range(0, 2) == 0);
            int mi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63))
                                                : int'($urandom_range(0, 1));
            int si = int'($urandom_range(0, 63));
            step(ld, st, ps, tk, mi, si);
        end
        idle(1);

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
